add3_seq_ctrl: RTL and testbench
================================

# add3_seq_ctrl

Upstream sequencer for the 3-bit registered two's-complement adder `Binary_add_3_1`. It accepts operand pairs on a valid/ready stream and drives the adder's `A`, `B` and `en` inputs. It captures the adder's `S` after its one-cycle latency and presents the sum plus a signed-overflow flag on a valid/ready output stream. One operation is in flight at a time.

## Interface
- No parameters; all widths fixed at 3 bits to match the adder.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept a pair.
- `in_a` in 3: operand A, two's complement.
- `in_b` in 3: operand B, two's complement.
- `add_a` out 3: to adder `A`.
- `add_b` out 3: to adder `B`.
- `add_en` out 1: to adder `en`.
- `add_s` in 3: from adder `S`, registered in the adder.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_s` out 3: captured sum.
- `out_ovf` out 1: signed overflow of `out_s`.
- `ops_cnt` out 8: completed operations (only with `ADD3_SEQ_STAT_EN`).
- `ovf_cnt` out 8: completed operations with overflow (only with `ADD3_SEQ_STAT_EN`).

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, HOLD. State is encoded in a register.
- IDLE
  - `in_ready`=1, combinational from state.
  - If `in_valid` is high at an edge: register `in_a`/`in_b` into `add_a`/`add_b`, set `add_en`=1, go to ISSUE.
- ISSUE
  - `add_en`=1 for exactly this cycle.
  - Next edge: adder latches the sum; `add_en`←0; go to CAPTURE.
- CAPTURE
  - Next edge: `out_s`←`add_s`.
  - Same edge: `out_ovf`←(`add_a[2]`==`add_b[2]`) && (`add_s[2]`!=`add_a[2]`).
  - Same edge: `out_valid`←1; go to HOLD.
- HOLD
  - `out_valid`, `out_s` and `out_ovf` stay stable until `out_ready` is high at an edge.
  - On that edge: `out_valid`←0; go to IDLE.
- `in_ready`=0 in ISSUE, CAPTURE and HOLD. No acceptance occurs in HOLD, even on the draining edge.
- `add_en`=0 in every state except ISSUE, so the adder holds `S` between operations.
- `add_a`/`add_b` hold the last issued operands until the next acceptance.
- Arithmetic: the sum is modulo 8. The sequencer does not recompute the sum; `out_s` is exactly what the adder produced.
- In-range results, for reference: (-4)+(3)=111, ovf=0; (3)+(3)=110, ovf=1; (-4)+(-4)=000, ovf=1.

## Timing
- Reset (`rst_n`=0 at an edge) sets the following values, with priority over every other condition:
  - state=IDLE
  - `add_a`=000, `add_b`=000, `add_en`=0
  - `out_valid`=0, `out_s`=000, `out_ovf`=0
  - `ops_cnt`=0, `ovf_cnt`=0
  - Because `in_ready` is derived from state, it reads 1 after reset.
- Reset mid-operation (ISSUE, CAPTURE or HOLD) discards the in-flight operation; no result is emitted.
- Latency: if accepted at edge k, `add_en` is high between edges k and k+1, and `out_valid` rises after edge k+2.
- Throughput: with `out_ready` held at 1, one operation per 4 cycles (accept at k, drain at k+3, next accept at k+4).
- `in_valid` high outside IDLE is ignored. The upstream source must hold its data until `in_ready` is seen.
- `out_ready` high while `out_valid`=0 has no effect.

## Configuration
- `ADD3_SEQ_STAT_EN` defined:
  - `ops_cnt` and `ovf_cnt` ports exist.
  - On each HOLD-drain edge, `ops_cnt`+=1; `ovf_cnt`+=1 if `out_ovf`=1.
  - Both counters saturate at 255 and clear on reset.
- `ADD3_SEQ_STAT_EN` undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset for 2 cycles, then `in_a`=001, `in_b`=010 at edge k → `add_en`=1 only in cycle k..k+1; `out_valid` rises after k+2 with `out_s`=011, `out_ovf`=0.
- Sweep all 64 pairs with `out_ready`=1 → each `out_s`=(a+b) mod 8, and `out_ovf`=1 exactly for signed sums outside -4..3 (e.g. 011+011 → 110, ovf=1; 100+100 → 000, ovf=1; 100+011 → 111, ovf=0).
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD → `out_valid`, `out_s` and `out_ovf` stay stable and `in_ready`=0; raise `out_ready` → drain in 1 cycle, and `in_ready`=1 the next cycle.
- Assert `rst_n`=0 for one edge while in CAPTURE → after that edge, `out_valid`=0, `out_s`=000, state=IDLE, and no result is emitted.
- Hold `in_valid`=1 with changing operands during ISSUE/CAPTURE/HOLD → only the pair present at the IDLE acceptance edge is used.
- With `ADD3_SEQ_STAT_EN`: 300 operations of 011+011 → `ops_cnt`=255 and `ovf_cnt`=255, both saturated.

Source files
------------

// File: rtl/add3_seq_ctrl.sv
// add3_seq_ctrl: valid/ready sequencer for the 3-bit registered adder Binary_add_3_1
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/in_a/in_b operand stream;
// add_a/add_b/add_en drive the adder, add_s is its registered sum;
// out_valid/out_ready/out_s/out_ovf result stream;
// ops_cnt/ovf_cnt saturating statistics, present only with ADD3_SEQ_STAT_EN defined.
module add3_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  output logic [2:0] add_a,
  output logic [2:0] add_b,
  output logic       add_en,
  input  logic [2:0] add_s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_s,
  output logic       out_ovf
`ifdef ADD3_SEQ_STAT_EN
  ,
  output logic [7:0] ops_cnt,
  output logic [7:0] ovf_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
  state_t state, state_nx;
  logic accept, drain;
  always_comb begin
    accept   = (state == IDLE) && in_valid;
    drain    = (state == HOLD) && out_ready;
    in_ready = (state == IDLE);
    add_en   = (state == ISSUE);
    state_nx = accept ? ISSUE :
               (state == ISSUE) ? CAPTURE :
               (state == CAPTURE) ? HOLD :
               drain ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      add_a     <= '0;
      add_b     <= '0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        add_a <= in_a;
        add_b <= in_b;
      end
      if (state == CAPTURE) begin
        out_s     <= add_s;
        out_ovf   <= (add_a[2] == add_b[2]) && (add_s[2] != add_a[2]);
        out_valid <= 1'b1;
      end
      if (drain) out_valid <= 1'b0;
    end
  end
`ifdef ADD3_SEQ_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_cnt <= '0;
      ovf_cnt <= '0;
    end else if (drain) begin
      if (ops_cnt != 8'hff) ops_cnt <= ops_cnt + 8'd1;
      if (out_ovf && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_add3_seq_ctrl.sv
// tb_add3_seq_ctrl: directed self-checking bench for add3_seq_ctrl with a behavioural adder
module tb_add3_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] in_a = '0, in_b = '0;
  logic [2:0] add_a, add_b;
  logic add_en;
  logic [2:0] add_s = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [2:0] out_s;
  logic out_ovf;
`ifdef ADD3_SEQ_STAT_EN
  logic [7:0] ops_cnt, ovf_cnt;
`endif
  int passed = 0;
  int total = 0;

  add3_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_s(add_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_ovf(out_ovf)
`ifdef ADD3_SEQ_STAT_EN
    , .ops_cnt(ops_cnt), .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // registered adder: S updates only on an enabled edge
  always @(posedge clk) if (add_en) add_s <= add_a + add_b;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] es, input logic eo);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " issue en"}, {7'd0, add_en}, 8'd1);
    chk({tag, " issue rdy"}, {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    chk({tag, " capt en"}, {7'd0, add_en}, 8'd0);
    chk({tag, " capt vld"}, {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    chk({tag, " hold vld"}, {7'd0, out_valid}, 8'd1);
    chk({tag, " sum"}, {5'd0, out_s}, {5'd0, es});
    chk({tag, " ovf"}, {7'd0, out_ovf}, {7'd0, eo});
    @(negedge clk);
    chk({tag, " drained"}, {7'd0, out_valid}, 8'd0);
    chk({tag, " rdy again"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    int sa, sb, ss;
    logic [2:0] sa3, sb3;
    logic [2:0] hs;
    logic ho;
    // reset for two cycles
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst add_en", {7'd0, add_en}, 8'd0);
    chk("rst add_a", {5'd0, add_a}, 8'd0);
    chk("rst add_b", {5'd0, add_b}, 8'd0);
    chk("rst out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst out_s", {5'd0, out_s}, 8'd0);
    chk("rst out_ovf", {7'd0, out_ovf}, 8'd0);
`ifdef ADD3_SEQ_STAT_EN
    chk("rst ops_cnt", ops_cnt, 8'd0);
    chk("rst ovf_cnt", ovf_cnt, 8'd0);
`endif
    // directed vectors, hand computed
    run_op("1+2", 3'b001, 3'b010, 3'b011, 1'b0);
    run_op("-4+3", 3'b100, 3'b011, 3'b111, 1'b0);
    run_op("3+3", 3'b011, 3'b011, 3'b110, 1'b1);
    run_op("-4+-4", 3'b100, 3'b100, 3'b000, 1'b1);
    run_op("-1+-1", 3'b111, 3'b111, 3'b110, 1'b0);
    run_op("2+-3", 3'b010, 3'b101, 3'b111, 1'b0);
    // full sweep of all 64 pairs
    for (int i = 0; i < 64; i++) begin
      sa3 = i[5:3];
      sb3 = i[2:0];
      sa = sa3[2] ? int'(sa3) - 8 : int'(sa3);
      sb = sb3[2] ? int'(sb3) - 8 : int'(sb3);
      ss = sa + sb;
      run_op($sformatf("sweep %0d+%0d", sa, sb), sa3, sb3, 3'((ss + 8) % 8),
             (ss > 3) || (ss < -4));
    end
    // backpressure, with in_valid held high and operands changing while busy
    in_a = 3'b011; in_b = 3'b011; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_a = 3'b001; in_b = 3'b001;
    @(negedge clk);
    in_a = 3'b010; in_b = 3'b000;
    @(negedge clk);
    hs = out_s; ho = out_ovf;
    chk("bp sum", {5'd0, hs}, 8'b110);
    chk("bp ovf", {7'd0, ho}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      in_a = 3'(i); in_b = 3'(i + 2);
      @(negedge clk);
      chk($sformatf("bp%0d vld", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("bp%0d sum", i), {5'd0, out_s}, 8'b110);
      chk($sformatf("bp%0d ovf", i), {7'd0, out_ovf}, 8'd1);
      chk($sformatf("bp%0d rdy", i), {7'd0, in_ready}, 8'd0);
      chk($sformatf("bp%0d opa", i), {5'd0, add_a}, 8'b011);
    end
    in_a = 3'b001; in_b = 3'b011; out_ready = 1'b1;
    @(negedge clk);
    chk("bp drain vld", {7'd0, out_valid}, 8'd0);
    chk("bp drain rdy", {7'd0, in_ready}, 8'd1);
    chk("bp no hold accept", {7'd0, add_en}, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post accept en", {7'd0, add_en}, 8'd1);
    chk("post accept a", {5'd0, add_a}, 8'b001);
    chk("post accept b", {5'd0, add_b}, 8'b011);
    @(negedge clk);
    @(negedge clk);
    chk("post sum", {5'd0, out_s}, 8'b100);
    chk("post ovf", {7'd0, out_ovf}, 8'd1);
    @(negedge clk);
    chk("post drained", {7'd0, out_valid}, 8'd0);
    // reset while in CAPTURE discards the operation
    run_op("pre-rst", 3'b010, 3'b001, 3'b011, 1'b0);
    in_a = 3'b001; in_b = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("capt state en", {7'd0, add_en}, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid rst vld", {7'd0, out_valid}, 8'd0);
    chk("mid rst sum", {5'd0, out_s}, 8'd0);
    chk("mid rst rdy", {7'd0, in_ready}, 8'd1);
    chk("mid rst add_a", {5'd0, add_a}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid rst quiet%0d", i), {7'd0, out_valid}, 8'd0);
    end
`ifdef ADD3_SEQ_STAT_EN
    run_op("stat1", 3'b011, 3'b011, 3'b110, 1'b1);
    run_op("stat2", 3'b001, 3'b001, 3'b010, 1'b0);
    chk("stat ops 2", ops_cnt, 8'd2);
    chk("stat ovf 1", ovf_cnt, 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_a = 3'b011; in_b = 3'b011; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("stat ops sat", ops_cnt, 8'd255);
    chk("stat ovf sat", ovf_cnt, 8'd255);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
